// File: rtl/onehot_stream_if.sv
// Handshake bundle for onehot_stream: index requests in, registered code words out.
// The slave view belongs to the decoder; the master view belongs to the producer/consumer side.
interface onehot_stream_if #(
   parameter int unsigned BINARY_WIDTH  = 4,
   parameter int unsigned ONE_HOT_WIDTH = 16,
   parameter int unsigned ERR_CNT_WIDTH = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [BINARY_WIDTH-1:0]  inp;
   logic [1:0]               mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [ONE_HOT_WIDTH-1:0] one_hot;
   logic                     out_err;
   logic [ERR_CNT_WIDTH-1:0] err_count;

   modport master (
      output in_valid, inp, mode, out_ready,
      input  in_ready, out_valid, one_hot, out_err, err_count
   );

   modport slave (
      input  in_valid, inp, mode, out_ready,
      output in_ready, out_valid, one_hot, out_err, err_count
   );
endinterface

// File: rtl/onehot_stream.sv
// Streaming binary-index decoder with one-hot, thermometer, ring-rotate and ring-load modes,
// range checking and a saturating out-of-range counter. One word per accept, 1-cycle latency.
module onehot_stream #(
   parameter int unsigned BINARY_WIDTH  = 4,
   parameter int unsigned ONE_HOT_WIDTH = 16,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   onehot_stream_if.slave bus
);
   localparam int unsigned W = ONE_HOT_WIDTH;

   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'd0,
      MODE_THERMO = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_LOAD   = 2'd3
   } mode_e;

   logic                     out_valid_q, out_valid_d;
   logic [W-1:0]             one_hot_q,   one_hot_d;
   logic                     out_err_q,   out_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;
   logic [W-1:0]             ring_q,      ring_d;

   logic                     in_ready;
   logic                     accept;
   logic                     in_range;
   mode_e                    mode;
   logic [W-1:0]             onehot_code;
   logic [W-1:0]             thermo_code;
   logic [2*W-1:0]           rot_wide;
   logic [W-1:0]             rot_code;

   assign mode     = mode_e'(bus.mode);
   assign in_ready = ~out_valid_q | bus.out_ready;
   assign accept   = bus.in_valid & in_ready;
   assign in_range = 32'(bus.inp) < W;

   always_comb begin
      onehot_code = '0;
      thermo_code = '0;
      for (int unsigned i = 0; i < W; i++) begin
         onehot_code[i] = (i == 32'(bus.inp));
         thermo_code[i] = (i <= 32'(bus.inp));
      end
   end

   // Rotate-left within W bits: shift a doubled copy and keep the upper half.
   assign rot_wide = {ring_q, ring_q} << bus.inp;
   assign rot_code = rot_wide[2*W-1:W];

   always_comb begin
      out_valid_d = out_valid_q;
      one_hot_d   = one_hot_q;
      out_err_d   = out_err_q;
      err_cnt_d   = err_cnt_q;
      ring_d      = ring_q;
      if (accept) begin
         out_valid_d = 1'b1;
         if (!in_range) begin
            one_hot_d = '0;
            out_err_d = 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
         end else begin
            out_err_d = 1'b0;
            unique case (mode)
               MODE_ONEHOT: one_hot_d = onehot_code;
               MODE_THERMO: one_hot_d = thermo_code;
               MODE_ROTATE: begin
                  ring_d    = rot_code;
                  one_hot_d = rot_code;
               end
               MODE_LOAD: begin
                  ring_d    = onehot_code;
                  one_hot_d = onehot_code;
               end
               default: ;
            endcase
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         one_hot_q   <= '0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         ring_q      <= {{(W-1){1'b0}}, 1'b1};
      end else begin
         out_valid_q <= out_valid_d;
         one_hot_q   <= one_hot_d;
         out_err_q   <= out_err_d;
         err_cnt_q   <= err_cnt_d;
         ring_q      <= ring_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.one_hot   = one_hot_q;
   assign bus.out_err   = out_err_q;
   assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_onehot_stream.sv
// Directed bench for onehot_stream: a 16-wide instance for the code modes and handshake,
// a 10-wide instance for range errors and counter saturation.
module tb_onehot_stream;
   typedef enum logic [1:0] {
      M_ONEHOT = 2'd0,
      M_THERMO = 2'd1,
      M_ROTATE = 2'd2,
      M_LOAD   = 2'd3
   } mode_e;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   onehot_stream_if #(.BINARY_WIDTH(4), .ONE_HOT_WIDTH(16), .ERR_CNT_WIDTH(8)) a_if ();
   onehot_stream_if #(.BINARY_WIDTH(4), .ONE_HOT_WIDTH(10), .ERR_CNT_WIDTH(8)) b_if ();

   onehot_stream #(.BINARY_WIDTH(4), .ONE_HOT_WIDTH(16), .ERR_CNT_WIDTH(8)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   onehot_stream #(.BINARY_WIDTH(4), .ONE_HOT_WIDTH(10), .ERR_CNT_WIDTH(8)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge with out_ready=1; checks the word one cycle later.
   task automatic a_send(input string tag, input mode_e m, input logic [3:0] i,
                         input logic [15:0] exp_oh);
      a_if.in_valid = 1'b1;
      a_if.mode     = m;
      a_if.inp      = i;
      @(negedge clk);
      chk({tag, ".valid"}, 32'(a_if.out_valid), 32'd1);
      chk({tag, ".code"},  32'(a_if.one_hot),   32'(exp_oh));
      chk({tag, ".err"},   32'(a_if.out_err),   32'd0);
      chk({tag, ".rdy"},   32'(a_if.in_ready),  32'd1);
   endtask

   task automatic b_send(input string tag, input mode_e m, input logic [3:0] i,
                         input logic [9:0] exp_oh, input logic exp_err, input logic [7:0] exp_cnt);
      b_if.in_valid = 1'b1;
      b_if.mode     = m;
      b_if.inp      = i;
      @(negedge clk);
      chk({tag, ".valid"}, 32'(b_if.out_valid), 32'd1);
      chk({tag, ".code"},  32'(b_if.one_hot),   32'(exp_oh));
      chk({tag, ".err"},   32'(b_if.out_err),   32'(exp_err));
      chk({tag, ".cnt"},   32'(b_if.err_count), 32'(exp_cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      a_if.in_valid = 1'b0;
      a_if.mode     = M_ONEHOT;
      a_if.inp      = '0;
      a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0;
      b_if.mode     = M_ONEHOT;
      b_if.inp      = '0;
      b_if.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst.valid", 32'(a_if.out_valid), 32'd0);
      chk("rst.code",  32'(a_if.one_hot),   32'd0);
      chk("rst.err",   32'(a_if.out_err),   32'd0);
      chk("rst.cnt",   32'(a_if.err_count), 32'd0);
      chk("rst.bcnt",  32'(b_if.err_count), 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst.rdy",   32'(a_if.in_ready),  32'd1);

      a_send("oh0",  M_ONEHOT, 4'd0,  16'h0001);
      a_send("oh5",  M_ONEHOT, 4'd5,  16'h0020);
      a_send("oh15", M_ONEHOT, 4'd15, 16'h8000);
      a_send("th0",  M_THERMO, 4'd0,  16'h0001);
      a_send("th3",  M_THERMO, 4'd3,  16'h000F);
      a_send("th15", M_THERMO, 4'd15, 16'hFFFF);
      a_send("ld14", M_LOAD,   4'd14, 16'h4000);
      a_send("rot3", M_ROTATE, 4'd3,  16'h0002);
      a_send("rot0", M_ROTATE, 4'd0,  16'h0002);
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("idle.valid", 32'(a_if.out_valid), 32'd0);

      // Backpressure: blocked ROTATE must neither be taken nor touch the ring.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.mode      = M_ONEHOT;
      a_if.inp       = 4'd4;
      @(negedge clk);
      chk("bp.valid", 32'(a_if.out_valid), 32'd1);
      chk("bp.code",  32'(a_if.one_hot),   32'h0010);
      chk("bp.rdy",   32'(a_if.in_ready),  32'd0);
      a_if.mode = M_ROTATE;
      a_if.inp  = 4'd2;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp.hold.code", 32'(a_if.one_hot),  32'h0010);
         chk("bp.hold.rdy",  32'(a_if.in_ready), 32'd0);
      end
      a_if.out_ready = 1'b1;
      #1;
      chk("bp.rel.rdy", 32'(a_if.in_ready), 32'd1);
      @(negedge clk);
      a_if.in_valid = 1'b0;
      chk("bp.second.valid", 32'(a_if.out_valid), 32'd1);
      chk("bp.second.code",  32'(a_if.one_hot),   32'h0008);
      @(negedge clk);
      chk("bp.nodup.valid",  32'(a_if.out_valid), 32'd0);

      b_send("b.oh12",  M_ONEHOT, 4'd12, 10'h000, 1'b1, 8'd1);
      b_send("b.rot11", M_ROTATE, 4'd11, 10'h000, 1'b1, 8'd2);
      b_send("b.rot1",  M_ROTATE, 4'd1,  10'h002, 1'b0, 8'd2);
      b_send("b.oh9",   M_ONEHOT, 4'd9,  10'h200, 1'b0, 8'd2);
      b_send("b.th10",  M_THERMO, 4'd10, 10'h000, 1'b1, 8'd3);
      b_if.mode = M_LOAD;
      b_if.inp  = 4'd15;
      repeat (300) @(negedge clk);
      chk("b.sat.cnt",  32'(b_if.err_count), 32'd255);
      chk("b.sat.err",  32'(b_if.out_err),   32'd1);
      chk("b.sat.code", 32'(b_if.one_hot),   32'd0);
      b_send("b.rot0",  M_ROTATE, 4'd0,  10'h002, 1'b0, 8'd255);
      b_if.in_valid = 1'b0;

      // Mid-stream reset with a word held and ring at 0x0100.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.mode      = M_LOAD;
      a_if.inp       = 4'd8;
      @(negedge clk);
      a_if.in_valid = 1'b0;
      chk("mrst.pre.valid", 32'(a_if.out_valid), 32'd1);
      chk("mrst.pre.code",  32'(a_if.one_hot),   32'h0100);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.valid", 32'(a_if.out_valid), 32'd0);
      chk("mrst.code",  32'(a_if.one_hot),   32'd0);
      chk("mrst.err",   32'(a_if.out_err),   32'd0);
      chk("mrst.bcnt",  32'(b_if.err_count), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      a_if.out_ready = 1'b1;
      a_send("mrst.rot1", M_ROTATE, 4'd1, 16'h0002);
      b_send("mrst.b.rot3", M_ROTATE, 4'd3, 10'h008, 1'b0, 8'd0);
      a_if.in_valid = 1'b0;
      b_if.in_valid = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/onehot_stream.md
Name: onehot_stream

Overview:
Registered, streaming successor to the combinational binary-to-one-hot decoder. Accepts binary indices over a valid/ready handshake and emits a registered code word per accepted index. Supports four modes: one-hot, thermometer, rotate-accumulate on an internal one-hot ring, and ring load. Flags out-of-range indices and counts them. Sits between index producers (schedulers, address decoders) and one-hot-consuming select/enable logic.

Parameters:
BINARY_WIDTH, 4, width of the input index.
ONE_HOT_WIDTH, 16, width of the output code; legal range 2..2**BINARY_WIDTH.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input index valid.
in_ready  output  1  block can accept this cycle.
inp  input  BINARY_WIDTH  unsigned binary index.
mode  input  2  code mode, sampled with inp: 0 ONEHOT, 1 THERMO, 2 ROTATE, 3 LOAD.
out_valid  output  1  output word valid.
out_ready  input  1  consumer accepts this cycle.
one_hot  output  ONE_HOT_WIDTH  registered code word.
out_err  output  1  word was produced from an out-of-range index; qualified by out_valid.
err_count  output  ERR_CNT_WIDTH  saturating count of accepted out-of-range indices.

Behaviour:
- Reset (rst_n low, async, any cycle): out_valid=0, one_hot=0, out_err=0, err_count=0, ring=1 (bit 0 set). in_ready=1 once out of reset. A word in flight is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
  - out_valid drops only on out_ready with no new accept.
  - Back-to-back accept plus drain in the same cycle sustains 1 word/cycle.
- Latency: word appears on one_hot the cycle after accept (1 cycle).
- Range check: inp >= ONE_HOT_WIDTH is out of range. The block sets out_err=1, one_hot=0, increments err_count (saturating at all-ones), and leaves ring unchanged, in every mode.
- In-range mode results, computed at accept time:
  - ONEHOT: one_hot = 1<<inp. Ring unchanged.
  - THERMO: bits 0..inp set, others 0 (inp=0 gives 1). Ring unchanged.
  - ROTATE: ring_next = ring rotated left by inp within ONE_HOT_WIDTH bits (inp=0 gives no change). ring<=ring_next. one_hot=ring_next.
  - LOAD: ring<=1<<inp; one_hot=1<<inp.
- In range, out_err=0.
- ring is always exactly one-hot; it is never all-zero after reset.
- No accept means no state change (ring, err_count frozen).
- An in_valid that is not accepted must not alter ring or err_count.
- When ONE_HOT_WIDTH=2**BINARY_WIDTH, no out-of-range input exists; out_err stays 0.

Test Plan:
- Reset, then ONEHOT inp=0,5,15 with out_ready=1 -> one_hot 0x0001, 0x0020, 0x8000 on consecutive cycles, out_err=0, in_ready held 1.
- THERMO inp=0,3,15 -> 0x0001, 0x000F, 0xFFFF.
- Ring sequence: LOAD inp=14, then ROTATE inp=3, then ROTATE inp=0 -> 0x4000, 0x0002 (wrap), 0x0002.
- ONE_HOT_WIDTH=10 (BINARY_WIDTH=4): ONEHOT inp=12, then ROTATE inp=11 -> both words one_hot=0 with out_err=1; err_count=2; following ROTATE inp=1 from ring=1 gives 0x002.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, one_hot stable for 5 cycles, second index not taken. Release -> second word one cycle later, no loss or duplicate.
- Assert rst_n low mid-stream with out_valid=1 and ring=0x0100 -> immediately out_valid=0, one_hot=0, err_count=0; after release, ROTATE inp=1 gives 0x0002. Separately, 300 out-of-range accepts -> err_count saturates at 255.
